// File: rtl/four_bool_fitness_sequencer.sv
// four_bool_fitness_sequencer: sweeps 16 input vectors into a 4-in/4-out candidate and scores its outputs against a target truth table
module four_bool_fitness_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [63:0] expected,
   output logic [3:0]  dut_in,
   input  logic [3:0]  dut_out,
   output logic        busy,
   output logic        done,
   output logic [6:0]  score,
   output logic        perfect,
   output logic [15:0] mismatch_mask
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  dut_in_q, dut_in_d;
   logic [6:0]  score_q, score_d;
   logic [15:0] mask_q, mask_d;
   logic [63:0] exp_q, exp_d;
   logic [3:0]  nibble, diff;
   logic [2:0]  hits;

   // next-state: abort beats everything while busy; SAMPLE scores the current vector and advances
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dut_in_d = dut_in_q;
      score_d  = score_q;
      mask_d   = mask_q;
      exp_d    = exp_q;
      nibble   = exp_q[{dut_in_q, 2'b00} +: 4];
      diff     = dut_out ^ nibble;
      hits     = 3'd4 - (3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]));
      if (abort && state_q != IDLE) begin
         state_d  = IDLE;
         dut_in_d = 4'd0;
         score_d  = 7'd0;
         mask_d   = 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  state_d  = SETTLE;
                  exp_d    = expected;
                  dut_in_d = 4'd0;
                  score_d  = 7'd0;
                  mask_d   = 16'd0;
                  cnt_d    = CNT_INIT;
               end
            end
            SETTLE: begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = SAMPLE;
            end
            SAMPLE: begin
               score_d          = score_q + 7'(hits);
               mask_d[dut_in_q] = |diff;
               if (dut_in_q == 4'hF) begin
                  state_d = DONE;
               end else begin
                  dut_in_d = dut_in_q + 4'd1;
                  cnt_d    = CNT_INIT;
                  state_d  = SETTLE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // state register with synchronous active-low reset discarding any partial result
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         dut_in_q <= 4'd0;
         score_q  <= 7'd0;
         mask_q   <= 16'd0;
         exp_q    <= 64'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dut_in_q <= dut_in_d;
         score_q  <= score_d;
         mask_q   <= mask_d;
         exp_q    <= exp_d;
      end
   end

   assign dut_in        = dut_in_q;
   assign busy          = state_q != IDLE;
   assign done          = state_q == DONE;
   assign score         = score_q;
   assign perfect       = score_q == 7'd64;
   assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_four_bool_fitness_sequencer.sv
// tb_four_bool_fitness_sequencer: directed table-driven checks of the fitness sequencer
module tb_four_bool_fitness_sequencer;

   localparam logic [63:0] IDENT = 64'hFEDCBA9876543210;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
   logic [63:0] expected = 64'd0;
   logic [3:0]  dut_in0, dut_in1, dut_out0, dut_out1;
   logic        busy0, busy1, done0, done1, perf0, perf1;
   logic [6:0]  score0, score1;
   logic [15:0] mask0, mask1;
   logic [3:0]  fault_v = 4'd0, fault_m = 4'd0;
   logic        sel = 1'b0;
   logic        c_busy, c_done, c_perf;
   logic [3:0]  c_dut_in;
   logic [6:0]  c_score;
   logic [15:0] c_mask;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   four_bool_fitness_sequencer u_dut (
      .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0), .expected(expected),
      .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0), .score(score0),
      .perfect(perf0), .mismatch_mask(mask0));

   four_bool_fitness_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1), .expected(expected),
      .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1), .score(score1),
      .perfect(perf1), .mismatch_mask(mask1));

   // candidate model: identity circuit with an optional bit fault on one vector
   always_comb begin
      dut_out0 = dut_in0 ^ ((dut_in0 == fault_v) ? fault_m : 4'h0);
      dut_out1 = dut_in1 ^ ((dut_in1 == fault_v) ? fault_m : 4'h0);
      c_busy   = sel ? busy1 : busy0;
      c_done   = sel ? done1 : done0;
      c_perf   = sel ? perf1 : perf0;
      c_dut_in = sel ? dut_in1 : dut_in0;
      c_score  = sel ? score1 : score0;
      c_mask   = sel ? mask1 : mask0;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run(input logic s, input logic [63:0] ex, input logic [3:0] fv, input logic [3:0] fm,
                      input int restart_at, input int abort_at, input int reset_at,
                      input logic [6:0] e_score, input logic e_perf, input logic [15:0] e_mask,
                      input string nm);
      int k, bad, per, lat, ndone;
      per = s ? 2 : 4;
      lat = 16 * per;
      sel = s;
      fault_v = fv;
      fault_m = fm;
      expected = ex;
      @(negedge clk);
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      chk({nm, " busy_on_accept"}, 64'(c_busy), 64'd1);
      k = 0;
      bad = 0;
      while (!c_done && k < 200) begin
         if (c_dut_in !== 4'(k / per)) bad++;
         if (k == 5) expected = ~ex;
         if (k == restart_at) begin
            if (s) start1 = 1'b1; else start0 = 1'b1;
         end
         if (k == abort_at) abort0 = 1'b1;
         if (k == reset_at) reset_n = 1'b0;
         @(negedge clk);
         k++;
         start0 = 1'b0;
         start1 = 1'b0;
         if (abort0 || !reset_n) begin
            abort0 = 1'b0;
            reset_n = 1'b1;
            chk({nm, " busy"}, 64'(c_busy), 64'd0);
            chk({nm, " done"}, 64'(c_done), 64'd0);
            chk({nm, " score"}, 64'(c_score), 64'd0);
            chk({nm, " perfect"}, 64'(c_perf), 64'd0);
            chk({nm, " mask"}, 64'(c_mask), 64'd0);
            chk({nm, " dut_in"}, 64'(c_dut_in), 64'd0);
            ndone = 0;
            repeat (lat + 8) begin
               @(negedge clk);
               if (c_done) ndone++;
            end
            chk({nm, " no_done"}, 64'(ndone), 64'd0);
            return;
         end
      end
      chk({nm, " latency"}, 64'(k), 64'(lat));
      chk({nm, " steps"}, 64'(bad), 64'd0);
      chk({nm, " score"}, 64'(c_score), 64'(e_score));
      chk({nm, " perfect"}, 64'(c_perf), 64'(e_perf));
      chk({nm, " mask"}, 64'(c_mask), 64'(e_mask));
      chk({nm, " busy_done"}, 64'(c_busy), 64'd1);
      @(negedge clk);
      chk({nm, " done_pulse"}, 64'(c_done), 64'd0);
      chk({nm, " busy_idle"}, 64'(c_busy), 64'd0);
      chk({nm, " dut_in_idle"}, 64'(c_dut_in), 64'd15);
      chk({nm, " score_hold"}, 64'(c_score), 64'(e_score));
   endtask

   typedef struct {
      logic [63:0] ex;
      logic [3:0]  fv;
      logic [3:0]  fm;
      logic [6:0]  sc;
      logic        pf;
      logic [15:0] mk;
      string       nm;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{IDENT,  4'd0,  4'h0, 7'd64, 1'b1, 16'h0000, "identity"};
      tbl[1] = '{~IDENT, 4'd0,  4'h0, 7'd0,  1'b0, 16'hFFFF, "inverted"};
      tbl[2] = '{IDENT,  4'd5,  4'h4, 7'd63, 1'b0, 16'h0020, "fault_v5b2"};
      tbl[3] = '{IDENT,  4'd0,  4'h1, 7'd63, 1'b0, 16'h0001, "fault_v0b0"};
      tbl[4] = '{IDENT,  4'd15, 4'hF, 7'd60, 1'b0, 16'h8000, "fault_v15all"};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst busy", 64'(busy0), 64'd0);
      chk("rst done", 64'(done0), 64'd0);
      chk("rst score", 64'(score0), 64'd0);
      chk("rst perfect", 64'(perf0), 64'd0);
      chk("rst dut_in", 64'(dut_in0), 64'd0);
      chk("rst mask", 64'(mask0), 64'd0);
      chk("rst1 busy", 64'(busy1), 64'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++)
         run(1'b0, tbl[i].ex, tbl[i].fv, tbl[i].fm, -1, -1, -1, tbl[i].sc, tbl[i].pf, tbl[i].mk, tbl[i].nm);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      chk("idle_abort score", 64'(score0), 64'd60);
      chk("idle_abort mask", 64'(mask0), 64'h8000);
      chk("idle_abort busy", 64'(busy0), 64'd0);
      start0 = 1'b1;
      abort0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      abort0 = 1'b0;
      chk("start_abort busy", 64'(busy0), 64'd0);
      @(negedge clk);
      chk("start_abort busy2", 64'(busy0), 64'd0);
      chk("start_abort score", 64'(score0), 64'd60);
      run(1'b0, IDENT, 4'd0, 4'h0, 10, -1, -1, 7'd64, 1'b1, 16'h0, "restart");
      run(1'b0, IDENT, 4'd0, 4'h0, -1, 20, -1, 7'd0, 1'b0, 16'h0, "abort");
      run(1'b0, IDENT, 4'd0, 4'h0, -1, -1, -1, 7'd64, 1'b1, 16'h0, "fresh");
      run(1'b0, IDENT, 4'd0, 4'h0, -1, -1, 30, 7'd0, 1'b0, 16'h0, "midreset");
      run(1'b1, IDENT, 4'd0, 4'h0, -1, -1, -1, 7'd64, 1'b1, 16'h0, "settle1");
      run(1'b1, IDENT, 4'd5, 4'h4, -1, -1, -1, 7'd63, 1'b0, 16'h0020, "settle1_fault");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
